pll_lock_supervisor: RTL and testbench
======================================

// Module: pll_lock_supervisor
// PURPOSE
//  Consumer end of the PLL interface. Runs on the 50 MHz reference clock and drives the PLL's active-high reset.
//  Watches the PLL's asynchronous locked output and releases the design reset only after lock has been stable.
//  On lock loss it re-asserts reset and re-runs PLL bring-up. Sits beside the 108 MHz PLL wrapper in the top level.
// PARAMETERS
//  RST_PULSE_CYCLES   10     PLL reset pulse width, refclk cycles (200 ns @ 50 MHz); >=1
//  LOCK_TIMEOUT       50000  refclk cycles to wait for lock per attempt (1 ms)
//  STABLE_CYCLES      1024   consecutive locked cycles required before release
//  MAX_RETRIES        3      failed attempts before FAULT; >=1
//  CNT_W              16     width of timer, >= clog2(max(LOCK_TIMEOUT,STABLE_CYCLES,RST_PULSE_CYCLES)+1)
// PORTS
//  refclk        in   1      reference clock, 50 MHz; sole clock
//  rst_n         in   1      synchronous, active-low reset
//  locked_async  in   1      PLL locked, asynchronous to refclk
//  pll_rst       out  1      active-high reset to PLL
//  sys_rst_n     out  1      active-low design reset (consumer re-synchronises into 108 MHz domain)
//  ready         out  1      1 while in RUN
//  fault         out  1      1 while in FAULT (sticky until rst_n)
//  retry_cnt     out  2      failed attempts in current bring-up, saturates at 3
//  loss_cnt      out  8      lock-loss events since reset (only with PLL_LOSS_CNT_EN)
// BEHAVIOUR
//  - locked_async passes through a 2-FF synchroniser -> lk; all decisions use lk (2-cycle input latency).
//  - Reset (rst_n=0 at posedge): state=PULSE, timer=0, retry=0.
//    Registered outputs: pll_rst=1, sys_rst_n=0, ready=0, fault=0, retry_cnt=0, loss_cnt=0, sync FFs=0.
//  - All outputs are registered; each reflects the state entered on the same edge.
//  - PULSE: pll_rst=1; timer counts 0..RST_PULSE_CYCLES-1, then ->WAIT, timer=0.
//  - WAIT: pll_rst=0, sys_rst_n=0.
//    lk=1 -> STABLE, timer=0.
//    Otherwise, if timer==LOCK_TIMEOUT-1: retry+1.
//      If the new retry==MAX_RETRIES -> FAULT; else -> PULSE.
//  - STABLE: lk=0 -> WAIT, timer=0 (glitch; no retry consumed).
//    timer==STABLE_CYCLES-1 with lk=1 -> RUN; sys_rst_n=1 and ready=1 on that edge; retry cleared.
//  - RUN: sys_rst_n=1. On lk=0: -> PULSE, sys_rst_n=0 and ready=0 on the next edge, loss_cnt+1 (saturating).
//  - FAULT: pll_rst=1, sys_rst_n=0, fault=1. Terminal until rst_n=0.
//  - retry_cnt = min(retry,3). Timer never wraps; it is cleared on every state change.
//  - Simultaneous events:
//    - rst_n=0 overrides everything.
//    - In WAIT, lk=1 on the timeout cycle -> STABLE (lock wins).
//  - Mid-operation reset: within one edge returns to PULSE with reset values; sys_rst_n goes low immediately.
// CONFIGURATION
//  PLL_LOSS_CNT_EN defined: loss_cnt port and counter present, 8-bit saturating at 255.
//    It counts RUN->PULSE transitions only.
//  PLL_LOSS_CNT_EN undefined: loss_cnt port absent; no counter logic. All other behaviour identical.
// STRUCTURE
//  Shared package pll_sup_pkg: state enum {PULSE, WAIT, STABLE, RUN, FAULT}; 3-bit state encoding;
//    constant REFCLK_HZ=50_000_000.
//  Sub-module sync_2ff (1-bit, reset to 0 via rst_n) for locked_async; reusable for other async inputs.
//  Remainder is one FSM + shared timer in this module.
// TESTING (bench uses RST_PULSE_CYCLES=10, LOCK_TIMEOUT=100, STABLE_CYCLES=16, MAX_RETRIES=3)
//  1. Reset release, locked rises 5 cycles after pll_rst falls and stays high.
//     -> pll_rst high exactly 10 cycles. sys_rst_n and ready rise 2+16 cycles after locked, +1 edge for registration.
//  2. Locked never rises -> three PULSE/WAIT rounds (retry_cnt 1,2), then fault=1, retry_cnt=3, pll_rst=1, sys_rst_n=0 held.
//  3. In STABLE, locked drops 1 cycle at count 8 -> back to WAIT, retry_cnt unchanged.
//     Release occurs 16 full lk cycles after re-lock.
//  4. In RUN, drop locked -> within 3 edges of the drop, sys_rst_n=0 and ready=0, pll_rst pulses 10 cycles.
//     loss_cnt=1 (PLL_LOSS_CNT_EN); relocks to RUN.
//  5. rst_n asserted for 1 cycle while in RUN -> next edge pll_rst=1, sys_rst_n=0, loss_cnt=0, retry_cnt=0.
//  6. Lock arrives exactly on timeout cycle of WAIT -> enters STABLE, retry_cnt not incremented.
//     Also build and run test 1 without PLL_LOSS_CNT_EN.

Source files
------------

// File: rtl/pll_sup_pkg.sv
// pll_sup_pkg
//   Shared definitions for the PLL lock supervisor: the supervisor state
//   enum (3-bit encoding), the reference clock frequency, and a helper that
//   saturates an attempt count to the 2-bit retry_cnt port.
package pll_sup_pkg;

  // Reference clock that the supervisor and its timer run on.
  localparam int unsigned REFCLK_HZ = 50_000_000;

  // Supervisor states.
  typedef enum logic [2:0] {
    PULSE  = 3'd0,
    WAIT   = 3'd1,
    STABLE = 3'd2,
    RUN    = 3'd3,
    FAULT  = 3'd4
  } pll_state_e;

  // Clamp an attempt count to what the 2-bit status port can show.
  function automatic logic [1:0] sat_retry(input int unsigned r);
    logic [1:0] res;
    if (r >= 32'd3) res = 2'd3;
    else            res = r[1:0];
    return res;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff
//   Two-flop synchroniser for a single asynchronous level signal.
//   Ports:
//     clk   in  1  destination clock
//     rst_n in  1  synchronous active-low reset, both flops clear to 0
//     d     in  1  asynchronous input
//     q     out 1  synchronised output, two clk edges behind d
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  // The first stage may go metastable; the second stage gives it a full
  // cycle to settle before anything downstream looks at it.
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Both stages clear on reset so the consumer sees "not locked" first.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor
//   Drives the PLL reset from the reference clock, watches the PLL locked
//   flag and only releases the design reset after lock has been stable.
//   On lock loss it re-asserts the design reset and restarts PLL bring-up;
//   after MAX_RETRIES failed attempts it parks in FAULT until rst_n.
//   Ports:
//     refclk       in  1  reference clock, sole clock
//     rst_n        in  1  synchronous active-low reset
//     locked_async in  1  PLL locked flag, asynchronous to refclk
//     pll_rst      out 1  active-high PLL reset
//     sys_rst_n    out 1  active-low design reset
//     ready        out 1  high while running with a stable lock
//     fault        out 1  high while parked in FAULT
//     retry_cnt    out 2  failed attempts in this bring-up, saturating at 3
//     loss_cnt     out 8  lock-loss events since reset (PLL_LOSS_CNT_EN only)
//   Build option: define PLL_LOSS_CNT_EN to add the loss_cnt port/counter.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int unsigned RST_PULSE_CYCLES = REFCLK_HZ / 5_000_000,
  parameter int unsigned LOCK_TIMEOUT     = REFCLK_HZ / 1_000,
  parameter int unsigned STABLE_CYCLES    = 1024,
  parameter int unsigned MAX_RETRIES      = 3,
  parameter int unsigned CNT_W            = 16
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       locked_async,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       ready,
  output logic       fault,
  output logic [1:0] retry_cnt
`ifdef PLL_LOSS_CNT_EN
  ,
  output logic [7:0] loss_cnt
`endif
);

  // Attempt counter needs to hold MAX_RETRIES; keep at least 2 bits.
  localparam int unsigned RETRY_W = (MAX_RETRIES >= 3) ? $clog2(MAX_RETRIES + 1) : 2;

  localparam logic [CNT_W-1:0]   PULSE_LAST   = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);

  logic lk;

  pll_state_e         state_q, state_d;
  logic [CNT_W-1:0]   timer_q, timer_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               pll_rst_q, pll_rst_d;
  logic               sys_rst_n_q, sys_rst_n_d;
  logic               ready_q, ready_d;
  logic               fault_q, fault_d;
  logic [1:0]         retry_cnt_q, retry_cnt_d;
`ifdef PLL_LOSS_CNT_EN
  logic [7:0]         loss_q, loss_d;
`endif

  // Bring the PLL's locked flag into the refclk domain.
  sync_2ff u_lock_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d     (locked_async),
    .q     (lk)
  );

  // Next-state logic. One shared timer serves every state and is cleared on
  // each transition, so each state's limit is measured from its own entry.
  // The registered outputs are decoded from the state being entered, so they
  // change on the same edge as the state itself.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    retry_d = retry_q;
`ifdef PLL_LOSS_CNT_EN
    loss_d  = loss_q;
`endif

    case (state_q)
      PULSE: begin
        if (timer_q == PULSE_LAST) begin
          state_d = WAIT;
          timer_d = '0;
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end

      WAIT: begin
        // A lock seen on the timeout cycle still counts as a lock.
        if (lk) begin
          state_d = STABLE;
          timer_d = '0;
        end else if (timer_q == TIMEOUT_LAST) begin
          retry_d = retry_q + RETRY_W'(1);
          timer_d = '0;
          state_d = (retry_d == RETRY_LIMIT) ? FAULT : PULSE;
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end

      STABLE: begin
        // A dropout here is a glitch, not a failed attempt.
        if (!lk) begin
          state_d = WAIT;
          timer_d = '0;
        end else if (timer_q == STABLE_LAST) begin
          state_d = RUN;
          timer_d = '0;
          retry_d = '0;
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end

      RUN: begin
        if (!lk) begin
          state_d = PULSE;
          timer_d = '0;
`ifdef PLL_LOSS_CNT_EN
          if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
`endif
        end
      end

      FAULT: begin
      end

      default: begin
        state_d = PULSE;
        timer_d = '0;
      end
    endcase

    pll_rst_d   = (state_d == PULSE) || (state_d == FAULT);
    sys_rst_n_d = (state_d == RUN);
    ready_d     = (state_d == RUN);
    fault_d     = (state_d == FAULT);
    retry_cnt_d = sat_retry(32'(retry_d));
  end

  // State, timer and registered outputs. Reset restarts bring-up at PULSE
  // with the PLL held in reset and the design reset asserted.
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      state_q     <= PULSE;
      timer_q     <= '0;
      retry_q     <= '0;
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
      retry_cnt_q <= 2'd0;
`ifdef PLL_LOSS_CNT_EN
      loss_q      <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      retry_q     <= retry_d;
      pll_rst_q   <= pll_rst_d;
      sys_rst_n_q <= sys_rst_n_d;
      ready_q     <= ready_d;
      fault_q     <= fault_d;
      retry_cnt_q <= retry_cnt_d;
`ifdef PLL_LOSS_CNT_EN
      loss_q      <= loss_d;
`endif
    end
  end

  assign pll_rst   = pll_rst_q;
  assign sys_rst_n = sys_rst_n_q;
  assign ready     = ready_q;
  assign fault     = fault_q;
  assign retry_cnt = retry_cnt_q;
`ifdef PLL_LOSS_CNT_EN
  assign loss_cnt  = loss_q;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb_pll_lock_supervisor
//   Scoreboard bench for pll_lock_supervisor. Stimulus is driven on the
//   falling edge; a behavioural model predicts the outputs after the next
//   rising edge and queues them; a monitor pops and compares just after each
//   rising edge. Directed bring-up scenarios are followed by random lock
//   activity with occasional resets.
module tb_pll_lock_supervisor;

  localparam int P_CYC   = 10;
  localparam int T_CYC   = 100;
  localparam int S_CYC   = 16;
  localparam int MAX_TRY = 3;

  logic       refclk;
  logic       rst_n;
  logic       locked_async;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       ready;
  logic       fault;
  logic [1:0] retry_cnt;
`ifdef PLL_LOSS_CNT_EN
  logic [7:0] loss_cnt;
`endif

  typedef struct {
    int cyc;
    bit pll_rst;
    bit sys_rst_n;
    bit ready;
    bit fault;
    int retry;
    int loss;
  } exp_t;

  exp_t exp_q[$];

  int  checks   = 0;
  int  failures = 0;
  int  cyc      = 0;
  bit  done     = 0;
  bit  cur_rst  = 0;
  bit  cur_lock = 0;

  // Reference model: named phase plus cycles remaining in it.
  string m_mode;
  int    m_left;
  int    m_retries;
  int    m_loss;
  bit    m_s1, m_s2;

  pll_lock_supervisor #(
    .RST_PULSE_CYCLES (P_CYC),
    .LOCK_TIMEOUT     (T_CYC),
    .STABLE_CYCLES    (S_CYC),
    .MAX_RETRIES      (MAX_TRY),
    .CNT_W            (16)
  ) dut (
    .refclk       (refclk),
    .rst_n        (rst_n),
    .locked_async (locked_async),
    .pll_rst      (pll_rst),
    .sys_rst_n    (sys_rst_n),
    .ready        (ready),
    .fault        (fault),
    .retry_cnt    (retry_cnt)
`ifdef PLL_LOSS_CNT_EN
    ,
    .loss_cnt     (loss_cnt)
`endif
  );

  // 50 MHz reference clock.
  initial begin
    refclk = 1'b0;
    forever #10 refclk = ~refclk;
  end

  // Advance the model across one rising edge with the given inputs. The lock
  // flag reaches the decision logic two edges after it is driven.
  task automatic modelStep(input bit r, input bit l);
    bit lk_now;
    if (!r) begin
      m_mode    = "PULSE";
      m_left    = P_CYC;
      m_retries = 0;
      m_loss    = 0;
      m_s1      = 1'b0;
      m_s2      = 1'b0;
      return;
    end
    lk_now = m_s2;
    m_s2   = m_s1;
    m_s1   = l;
    if (m_mode == "PULSE") begin
      m_left--;
      if (m_left == 0) begin
        m_mode = "WAIT";
        m_left = T_CYC;
      end
    end else if (m_mode == "WAIT") begin
      if (lk_now) begin
        m_mode = "STABLE";
        m_left = S_CYC;
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_retries++;
          m_mode = (m_retries == MAX_TRY) ? "FAULT" : "PULSE";
          m_left = P_CYC;
        end
      end
    end else if (m_mode == "STABLE") begin
      if (!lk_now) begin
        m_mode = "WAIT";
        m_left = T_CYC;
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_mode    = "RUN";
          m_retries = 0;
        end
      end
    end else if (m_mode == "RUN") begin
      if (!lk_now) begin
        m_mode = "PULSE";
        m_left = P_CYC;
        if (m_loss < 255) m_loss++;
      end
    end
  endtask

  // Drive one cycle of inputs and queue what the DUT must show afterwards.
  task automatic applyStimulus(input bit r, input bit l);
    exp_t e;
    @(negedge refclk);
    rst_n        = r;
    locked_async = l;
    cur_rst      = r;
    cur_lock     = l;
    cyc++;
    modelStep(r, l);
    e.cyc       = cyc;
    e.pll_rst   = (m_mode == "PULSE") || (m_mode == "FAULT");
    e.sys_rst_n = (m_mode == "RUN");
    e.ready     = (m_mode == "RUN");
    e.fault     = (m_mode == "FAULT");
    e.retry     = (m_retries > 3) ? 3 : m_retries;
    e.loss      = m_loss;
    exp_q.push_back(e);
  endtask

  task automatic compareVal(input string name, input int act, input int req, input int c);
    checks++;
    if (act != req) begin
      failures++;
      $display("[TB] FAIL %s cycle=%0d actual=%0d expected=%0d", name, c, act, req);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    compareVal("pll_rst",   int'(pll_rst),   int'(e.pll_rst),   e.cyc);
    compareVal("sys_rst_n", int'(sys_rst_n), int'(e.sys_rst_n), e.cyc);
    compareVal("ready",     int'(ready),     int'(e.ready),     e.cyc);
    compareVal("fault",     int'(fault),     int'(e.fault),     e.cyc);
    compareVal("retry_cnt", int'(retry_cnt), e.retry,           e.cyc);
`ifdef PLL_LOSS_CNT_EN
    compareVal("loss_cnt",  int'(loss_cnt),  e.loss,            e.cyc);
`endif
  endtask

  // Keep the current inputs until the model reaches the given phase and
  // remaining count; a miss within the budget is reported as a failure.
  task automatic waitModel(input string mode, input int left, input int limit);
    int n;
    n = 0;
    while (!(m_mode == mode && m_left == left)) begin
      if (n == limit) begin
        failures++;
        $display("[TB] FAIL wait_%s cycle=%0d actual=%s expected=%s", mode, cyc, m_mode, mode);
        return;
      end
      applyStimulus(cur_rst, cur_lock);
      n++;
    end
  endtask

  // Monitor: compare the oldest expectation just after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge refclk);
      #1;
      if (done) break;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput(e);
      end
    end
  end

  // Absolute time limit so the run always ends.
  initial begin
    #2ms;
    $display("[TB] FAIL watchdog cycle=%0d actual=running expected=finished", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  // Stimulus: directed scenarios, then random lock activity.
  initial begin
    bit lv;
    int len;
    rst_n        = 1'b0;
    locked_async = 1'b0;
    m_mode       = "PULSE";
    m_left       = P_CYC;
    m_retries    = 0;
    m_loss       = 0;
    m_s1         = 1'b0;
    m_s2         = 1'b0;

    $display("[TB] normal bring-up");
    repeat (3) applyStimulus(0, 0);
    applyStimulus(1, 0);
    waitModel("WAIT", T_CYC, 40);
    repeat (5) applyStimulus(1, 0);
    repeat (40) applyStimulus(1, 1);

    $display("[TB] lock loss in RUN");
    repeat (3) applyStimulus(1, 0);
    repeat (60) applyStimulus(1, 1);

    $display("[TB] reset pulse while running");
    applyStimulus(0, 1);
    repeat (50) applyStimulus(1, 1);

    $display("[TB] lock never arrives");
    applyStimulus(0, 0);
    repeat (360) applyStimulus(1, 0);

    $display("[TB] glitch during stable count");
    applyStimulus(0, 0);
    applyStimulus(1, 0);
    waitModel("WAIT", T_CYC, 40);
    applyStimulus(1, 1);
    waitModel("STABLE", S_CYC - 8, 40);
    applyStimulus(1, 0);
    repeat (40) applyStimulus(1, 1);

    $display("[TB] lock on the timeout cycle");
    applyStimulus(0, 0);
    applyStimulus(1, 0);
    waitModel("WAIT", 3, 200);
    repeat (40) applyStimulus(1, 1);

    $display("[TB] random lock activity");
    for (int seg = 0; seg < 120; seg++) begin
      if ($urandom_range(0, 24) == 0) begin
        repeat ($urandom_range(1, 2)) applyStimulus(0, cur_lock);
      end
      lv  = ($urandom_range(0, 3) != 0);
      len = lv ? int'($urandom_range(5, 60)) : int'($urandom_range(1, 30));
      repeat (len) applyStimulus(1, lv);
    end

    repeat (2) @(negedge refclk);
    done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
